// File: rtl/debug_pkg.sv
// Shared debug-path types and constants.
// Used by the step controller and the VGA overlay.
package debug_pkg;

  typedef enum logic [1:0] {
    STEP,
    RUN,
    HALT
  } step_state_t;

  localparam int   RATE_SEL_W     = 3;
  localparam logic KEY_IDLE_LEVEL = 1'b1;
  localparam logic SW_IDLE_LEVEL  = 1'b0;

  // Reload value for the free-run down-counter.
  // A shift that reaches zero is clamped to a one-cycle period.
  function automatic logic [31:0] rate_reload(
    input logic [31:0]           base,
    input logic [RATE_SEL_W-1:0] sel
  );
    logic [31:0] period;
    period = base >> sel;
    return (period == 32'd0) ? 32'd0 : period - 32'd1;
  endfunction

endpackage

// File: rtl/debouncer.sv
// Push-button synchronizer and debouncer.
// Emits the stable level and a one-cycle press strobe.
module debouncer
  import debug_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   level_q;
  logic                   level_d;
  logic                   press_q;
  logic                   press_d;
  logic                   key_s;

  assign key_s = sync_q[SYNC_STAGES-1];

  // Accept a new level only after it held for the full window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (key_s != level_q) begin
      if (cnt_q == LAST) begin
        level_d = key_s;
        press_d = level_q & ~key_s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer chain, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{KEY_IDLE_LEVEL}};
      cnt_q   <= '0;
      level_q <= KEY_IDLE_LEVEL;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], key_n_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/step_controller.sv
// CPU clock-enable generator: manual step,
// free-run at a selectable rate, PC breakpoint halt.
module step_controller
  import debug_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  key_step_n,
  input  logic                  sw_run,
  input  logic [RATE_SEL_W-1:0] run_rate,
  input  logic                  bp_en,
  input  logic [31:0]           bp_addr,
  input  logic [31:0]           pc_value,
  output logic                  cpu_step,
  output logic [31:0]           step_count,
  output logic                  running,
  output logic                  halted,
  output logic                  key_level
);

  logic        press;
  logic [1:0]  run_sync_q;
  logic [1:0]  bp_sync_q;
  logic        run_prev_q;
  logic        run_s;
  logic        run_rise;
  logic        bp_hit;
  logic [31:0] reload;

  step_state_t state_q;
  step_state_t state_d;
  logic [31:0] rate_q;
  logic [31:0] rate_d;
  logic        step_q;
  logic        step_d;
  logic [31:0] step_count_q;
  logic        running_q;
  logic        halted_q;

  debouncer #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key (
    .clk     (clk),
    .rst_n   (reset_n),
    .key_n_i (key_step_n),
    .level_o (key_level),
    .press_o (press)
  );

  assign run_s    = run_sync_q[1];
  assign run_rise = run_s & ~run_prev_q;
  assign bp_hit   = bp_sync_q[1] && (pc_value == bp_addr);
  assign reload   = rate_reload(32'(CLK_HZ), run_rate);

  // Switch synchronizers and resume-edge history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_sync_q <= {2{SW_IDLE_LEVEL}};
      bp_sync_q  <= {2{SW_IDLE_LEVEL}};
      run_prev_q <= SW_IDLE_LEVEL;
    end else begin
      run_sync_q <= {run_sync_q[0], sw_run};
      bp_sync_q  <= {bp_sync_q[0], bp_en};
      run_prev_q <= run_s;
    end
  end

  // Next mode, step request and rate counter.
  // Leaving RUN takes priority over a same-cycle tick.
  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    step_d  = 1'b0;
    unique case (state_q)
      STEP: begin
        step_d = press;
        if (run_s) begin
          state_d = RUN;
          rate_d  = reload;
        end
      end
      RUN: begin
        if (!run_s) begin
          state_d = STEP;
        end else if (rate_q == 32'd0) begin
          rate_d = reload;
          if (bp_hit) begin
            state_d = HALT;
          end else begin
            step_d = 1'b1;
          end
        end else begin
          rate_d = rate_q - 32'd1;
        end
      end
      HALT: begin
        step_d = press;
        if (!run_s) begin
          state_d = STEP;
        end else if (run_rise) begin
          state_d = RUN;
          rate_d  = reload;
        end
      end
      default: state_d = STEP;
    endcase
  end

  // Mode register with registered step/flag outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= STEP;
      rate_q       <= '0;
      step_q       <= 1'b0;
      step_count_q <= '0;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rate_q    <= rate_d;
      step_q    <= step_d;
      running_q <= (state_d == RUN);
      halted_q  <= (state_d == HALT);
      if (step_d) begin
        step_count_q <= step_count_q + 32'd1;
      end
    end
  end

  assign cpu_step   = step_q;
  assign step_count = step_count_q;
  assign running    = running_q;
  assign halted     = halted_q;

endmodule

// File: doc/step_controller.md
# step_controller

- Clock-enable generator that sits directly upstream of the processor core.
- Replaces the raw push-button clock with a debounced, synchronous, single-cycle `cpu_step` enable in the `CLOCK_50` domain.
- Provides three modes: manual single-step, free-run at a switch-selected rate, and halt on a PC breakpoint.
- Exposes step count and mode flags for the 7-segment, LED and VGA debug paths.

## Interface

Parameters:
- `CLK_HZ`, 50_000_000, input clock frequency; the base free-run period in cycles.
- `DEBOUNCE_CYCLES`, 1_000_000, cycles the synchronized key must hold a new level before it is accepted (20 ms).
- `SYNC_STAGES`, 2, synchronizer flops on the raw key input (≥2).

Ports:
- `clk`  in  1  `CLOCK_50` domain clock; the single clock of the block.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `key_step_n`  in  1  raw push-button, active-low, asynchronous to `clk`.
- `sw_run`  in  1  1 = free-run request, 0 = manual step mode; asynchronous, synchronized internally.
- `run_rate`  in  3  free-run rate select; period = `CLK_HZ >> run_rate` cycles.
- `bp_en`  in  1  breakpoint enable; asynchronous, synchronized internally.
- `bp_addr`  in  32  breakpoint PC; quasi-static.
- `pc_value`  in  32  current processor PC.
- `cpu_step`  out  1  one-cycle enable; the processor advances exactly once per high cycle.
- `step_count`  out  32  number of `cpu_step` pulses issued since reset; wraps modulo 2^32.
- `running`  out  1  state == RUN.
- `halted`  out  1  state == HALT.
- `key_level`  out  1  debounced key level, active-low.

## Operation

Key path:
- `key_step_n` passes through `SYNC_STAGES` flops.
- The debounce counter clears whenever the synchronized level equals `key_level`.
- Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1`, `key_level` takes the new level and the counter clears.
- A 1→0 transition of `key_level` is a `press` event, one cycle wide. Releases produce no event.

`sw_run` and `bp_en` are 2-flop synchronized. A `run_rise` event is detected on the synchronized `sw_run`.

Rate tick:
- Down-counter, active only in RUN. Loads `(CLK_HZ >> run_rate) - 1` on entry to RUN and on each tick.
- `tick` fires when the counter is 0.
- A `run_rate` change takes effect at the next reload.

State machine, states STEP, RUN, HALT:
- STEP: `press` → `cpu_step`. `sw_run`=1 → RUN.
- RUN, on `tick`:
  - If `bp_en` and `pc_value == bp_addr`: go to HALT, no `cpu_step`. The breakpoint instruction is not executed.
  - Otherwise: `cpu_step`.
- RUN: `press` is ignored. `sw_run`=0 → STEP, and a coincident tick is discarded.
- HALT: `press` → `cpu_step`, so the user steps past the breakpoint manually. `sw_run`=0 → STEP.
- HALT → RUN requires `run_rise` (switch lowered, then raised). A held `sw_run` does not resume.

`step_count` increments on every `cpu_step` and wraps from `FFFF_FFFF` to 0.

Reset (`reset_n` low, any time, including mid-debounce or mid-tick):
- State STEP.
- `cpu_step` 0, `step_count` 0, `running` 0, `halted` 0, `key_level` 1.
- All counters 0; synchronizer flops 1 for the key, 0 for the switches.

## Timing

- All outputs are registered.
- `cpu_step` is high for exactly one cycle, asserted the cycle after `press` or `tick`.
- Key press latency, from stable low on the pin to `cpu_step` high: `SYNC_STAGES + DEBOUNCE_CYCLES + 1` cycles.
- Glitches shorter than `DEBOUNCE_CYCLES` never produce `press`.
- Free-run: consecutive `cpu_step` pulses are exactly `CLK_HZ >> run_rate` cycles apart.
- Breakpoint compare uses `pc_value` in the cycle the tick occurs. The processor updates PC on `cpu_step`, so the compare is always against the next instruction to execute.
- `halted` rises in the same cycle `cpu_step` would have.
- Mode change: RUN → STEP appears 1 cycle after the synchronized `sw_run` falls. The first tick after entering RUN comes one full period later.

## Structure

- Shared package `debug_pkg` holds:
  - `typedef enum logic [1:0] {STEP, RUN, HALT} step_state_t`
  - rate-shift and reset-level constants, reused by the VGA debug overlay to print the mode.
- One sub-module: `debouncer` (synchronizer, counter, level and press outputs, parameterised by `SYNC_STAGES`/`DEBOUNCE_CYCLES`). It is reused for `KEY[1]`.
- The FSM, rate counter, breakpoint compare and step counter live in `step_controller`.

## Test plan

Bench parameters: `CLK_HZ`=64, `DEBOUNCE_CYCLES`=4.

- Clean press held 20 cycles, STEP mode → one `cpu_step` 7 cycles after the pin falls; `step_count`=1; release gives no pulse.
- Bounce 0/1 every 2 cycles for 12 cycles, then stable low → exactly one `cpu_step`, only after the stable low.
- `sw_run`=1, `run_rate`=2 → `cpu_step` every 16 cycles; after 5 pulses `step_count`=5; presses during RUN add nothing.
- RUN, `bp_en`=1, `bp_addr`=0x10, PC stepping +4 from 0 → 4 pulses (PC 0,4,8,C), then `halted`=1 with PC=0x10 and no further ticks; one press → one `cpu_step`, still HALT; `sw_run` 0→1 → RUN.
- `reset_n` low mid-RUN with `step_count`=0xFFFF_FFFF preloaded via pulses/force → all outputs at reset values within one cycle, asynchronously. Separately, an increment at 0xFFFF_FFFF wraps to 0.
- `sw_run` falls in the same cycle as a tick → no `cpu_step`; state STEP next cycle.
